// File: rtl/aes_128_enc_iter.sv
// aes_128_enc_iter: iterative AES-128 encryptor, one round per clock, key expanded on the fly.
// Optional abort port is enabled by defining AES_ENC_ABORT_EN.
module aes_128_enc_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] cipher,
  output logic         busy
);
  localparam logic [3:0] LAST = 4'(NR);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t           state_q;
  logic [0:15][7:0] st_q, rk_q, sb_d, sr_d, mc_d, round_d, nk_d;
  logic [0:3][31:0] w_d, n_d;
  logic [31:0]      tmp_d;
  logic [3:0]       rnd_q;
  logic [7:0]       rcon;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // SubBytes then ShiftRows: byte r+4c takes column (c+r) mod 4 of row r
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign sb_d[i] = SBOX[st_q[i]];
    assign sr_d[i] = sb_d[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
  end
  // MixColumns over each of the four columns
  for (genvar c = 0; c < 4; c++) begin : g_c
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = {sr_d[4*c], sr_d[4*c+1], sr_d[4*c+2], sr_d[4*c+3]};
    assign mc_d[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc_d[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc_d[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc_d[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end
  // Round constant for the key step taken on this round
  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end
  // Single key-expansion step: SubWord(RotWord(w3)) ^ rcon chained through the four words
  assign w_d    = rk_q;
  assign tmp_d  = {SBOX[rk_q[13]] ^ rcon, SBOX[rk_q[14]], SBOX[rk_q[15]], SBOX[rk_q[12]]};
  assign n_d[0] = w_d[0] ^ tmp_d;
  assign n_d[1] = w_d[1] ^ n_d[0];
  assign n_d[2] = w_d[2] ^ n_d[1];
  assign n_d[3] = w_d[3] ^ n_d[2];
  assign nk_d   = n_d;
  assign round_d = (rnd_q == LAST ? sr_d : mc_d) ^ nk_d;
  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      rk_q      <= '0;
      rnd_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cipher    <= '0;
    end
`ifdef AES_ENC_ABORT_EN
    else if (abort && state_q != IDLE) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end
`endif
    else begin
      case (state_q)
        IDLE: if (in_valid) begin
          st_q     <= in ^ key;
          rk_q     <= key;
          rnd_q    <= 4'd1;
          state_q  <= ROUND;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        ROUND: if (rnd_q == 4'd0 || rnd_q > LAST) begin
          state_q  <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end else begin
          st_q  <= round_d;
          rk_q  <= nk_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == LAST) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            cipher    <= round_d;
          end
        end
        DONE: if (out_ready) begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_128_enc_iter.sv
// tb_aes_128_enc_iter: vector table, corner sequences and scoreboard against a software AES model.
module tb_aes_128_enc_iter;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [127:0] din = '0, kin = '0, cipher;
`ifdef AES_ENC_ABORT_EN
  logic abort = 1'b0;
`endif
  int errors = 0, checks = 0, nres = 0, lat;
  logic [7:0] sb [256], isb [256];
  logic [127:0] sbq [$], got [$];
  typedef struct {logic [127:0] pt, key, ct;} vec_t;
  vec_t tv [4];

  always #5 clk = ~clk;

  aes_128_enc_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din), .key(kin),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_ENC_ABORT_EN
    .abort(abort),
`endif
    .cipher(cipher), .busy(busy));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [1407:0] kexp(input logic [127:0] k);
    logic [1407:0] ks;
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    ks[1407 -: 128] = k;
    for (int i = 4; i < 44; i++) begin
      t = ks[1407-32*(i-1) -: 32];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
        rc = gmul(rc, 8'h02);
      end
      ks[1407-32*i -: 32] = ks[1407-32*(i-4) -: 32] ^ t;
    end
    return ks;
  endfunction

  function automatic logic [127:0] subb(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int b = 0; b < 16; b++) y[127-8*b -: 8] = inv ? isb[x[127-8*b -: 8]] : sb[x[127-8*b -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] shift(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (inv) y[127-8*(r+4*((c+r)%4)) -: 8] = x[127-8*(r+4*c) -: 8];
        else     y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0] m [4];
    logic [7:0] acc;
    m = inv ? '{8'd14, 8'd11, 8'd13, 8'd9} : '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(x[127-8*((r+j)%4+4*c) -: 8], m[j]);
        y[127-8*(r+4*c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    logic [1407:0] ks = kexp(k);
    logic [127:0] x = p ^ ks[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      x = shift(subb(x, 1'b0), 1'b0);
      if (r < 10) x = mix(x, 1'b0);
      x ^= ks[1407-128*r -: 128];
    end
    return x;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input logic [127:0] k);
    logic [1407:0] ks = kexp(k);
    logic [127:0] x = ct ^ ks[1407-1280 -: 128];
    for (int r = 9; r >= 0; r--) begin
      x = subb(shift(x, 1'b1), 1'b1) ^ ks[1407-128*r -: 128];
      if (r > 0) x = mix(x, 1'b1);
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  task automatic accept(input logic [127:0] p, input logic [127:0] k);
    int n = 0;
    din = p; kin = k; in_valid = 1'b1;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 40) begin @(posedge clk); #1; l++; end
  endtask

  task automatic quiet(input string nm);
    logic seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; seen |= out_valid; end
    chk(nm, 128'(seen), 128'd0);
  endtask

  // Scoreboard: push model result at each accept, compare at each output handshake
  always @(negedge clk) if (!rst) begin
    if (in_valid && in_ready) sbq.push_back(enc(din, kin));
    if (out_valid && out_ready) begin
      nres++;
      got.push_back(cipher);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: unexpected output %h", cipher);
      end else chk("scoreboard", cipher, sbq.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] pts [3], keys [3], prev;
    int n0, w;
    logic [7:0] v, b;
    tv[0] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tv[1] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32};
    tv[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    tv[3] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a, key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97};
    for (int a = 0; a < 256; a++) begin
      v = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) v = 8'(x);
      b = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      sb[a] = b;
      isb[b] = 8'(a);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_cipher", cipher, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      accept(tv[i].pt, tv[i].key);
      chk("busy_round", 128'(busy), 128'd1);
      wait_out(lat);
      chk("latency", 128'(lat), 128'd10);
      chk("vector_cipher", cipher, tv[i].ct);
      @(posedge clk); #1;
      chk("in_ready_return", 128'(in_ready), 128'd1);
      chk("out_valid_drop", 128'(out_valid), 128'd0);
    end
    accept(tv[1].pt, tv[1].key);
    @(posedge clk); #1;
    chk("appb_round1", dut.st_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_out(lat);
    chk("appb_cipher", cipher, tv[1].ct);
    @(posedge clk); #1;
    out_ready = 1'b0;
    accept(tv[0].pt, tv[0].key);
    wait_out(lat);
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_cipher", cipher, tv[0].ct);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    accept(tv[0].pt, tv[0].key);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_cipher", cipher, 128'd0);
    quiet("midrst_no_output");
    accept(tv[1].pt, tv[1].key);
    wait_out(lat);
    chk("midrst_next_cipher", cipher, tv[1].ct);
    @(posedge clk); #1;
    n0 = nres;
    got.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      keys[i] = {$urandom, $urandom, $urandom, $urandom};
      din = pts[i]; kin = keys[i];
      w = 0;
      while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    w = 0;
    while (nres < n0 + 3 && w < 60) begin @(posedge clk); #1; w++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_count", 128'(nres - n0), 128'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk("loopback", dec(got[i], keys[i]), pts[i]);
      else begin checks++; errors++; $display("FAIL loopback: block %0d missing", i); end
`ifdef AES_ENC_ABORT_EN
    accept(tv[0].pt, tv[0].key);
    repeat (2) begin @(posedge clk); #1; end
    prev = cipher;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sbq.delete();
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_cipher", cipher, prev);
    quiet("abort_no_output");
    abort = 1'b1;
    accept(tv[1].pt, tv[1].key);
    abort = 1'b0;
    chk("abort_idle_accept", 128'(busy), 128'd1);
    wait_out(lat);
    chk("abort_next_cipher", cipher, tv[1].ct);
    @(posedge clk); #1;
`endif
    chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
